// File: rtl/collision_scanner.sv
// collision_scanner
//   Walks a bullet table one slot per cycle and reports which active bullets
//   overlap the player's bounding box. The table is read through a 1-cycle
//   synchronous port: rd_idx goes out, and the slot data comes back on the
//   next cycle.
//
//   Ports
//     clk, reset            clock, synchronous active-high reset
//     start, first_only     pass request (sampled in IDLE), stop-at-first-hit mode
//     px, py, lpx, lpy      player centre and full width/height (latched at start)
//     rd_idx                bullet-table read address
//     b_active,bx,by,lbx,lby  slot data for the previous cycle's rd_idx
//     busy, done            pass in progress, one-cycle completion pulse
//     hit, hit_idx,         result: any overlap, lowest overlapping slot,
//     hit_mask, hit_count   per-slot overlap bits, number of overlaps
module collision_scanner #(
  parameter int N_BULLETS = 8,
  parameter int COORD_W   = 8,
  parameter int IDX_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 first_only,
  input  logic [COORD_W-1:0]   px,
  input  logic [COORD_W-1:0]   py,
  input  logic [COORD_W-1:0]   lpx,
  input  logic [COORD_W-1:0]   lpy,
  output logic [IDX_W-1:0]     rd_idx,
  input  logic                 b_active,
  input  logic [COORD_W-1:0]   bx,
  input  logic [COORD_W-1:0]   by,
  input  logic [COORD_W-1:0]   lbx,
  input  logic [COORD_W-1:0]   lby,
  output logic                 busy,
  output logic                 done,
  output logic                 hit,
  output logic [IDX_W-1:0]     hit_idx,
  output logic [N_BULLETS-1:0] hit_mask,
  output logic [IDX_W:0]       hit_count
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] lx;
    logic [COORD_W-1:0] ly;
  } box_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BULLETS - 1);

  state_t               state_q,     state_d;
  box_t                 player_q,    player_d;
  logic                 fo_q,        fo_d;
  logic [IDX_W-1:0]     rd_idx_q,    rd_idx_d;
  // eval_vld_q marks cycles where b_* carries slot eval_idx_q
  logic                 eval_vld_q,  eval_vld_d;
  logic [IDX_W-1:0]     eval_idx_q,  eval_idx_d;
  logic                 hit_q,       hit_d;
  logic [IDX_W-1:0]     hit_idx_q,   hit_idx_d;
  logic [N_BULLETS-1:0] hit_mask_q,  hit_mask_d;
  logic [IDX_W:0]       hit_count_q, hit_count_d;

  // Overlap test in COORD_W+1 bits so distances and half-extent sums never wrap.
  logic [COORD_W:0] dx, dy, sx, sy;
  logic             slot_hit;

  always_comb begin
    dx = (player_q.x >= bx) ? ({1'b0, player_q.x} - {1'b0, bx})
                            : ({1'b0, bx} - {1'b0, player_q.x});
    dy = (player_q.y >= by) ? ({1'b0, player_q.y} - {1'b0, by})
                            : ({1'b0, by} - {1'b0, player_q.y});
    sx = ({1'b0, player_q.lx} >> 1) + ({1'b0, lbx} >> 1);
    sy = ({1'b0, player_q.ly} >> 1) + ({1'b0, lby} >> 1);
    slot_hit = eval_vld_q && b_active && (dx <= sx) && (dy <= sy);
  end

  always_comb begin
    state_d     = state_q;
    player_d    = player_q;
    fo_d        = fo_q;
    rd_idx_d    = rd_idx_q;
    eval_vld_d  = 1'b0;
    eval_idx_d  = eval_idx_q;
    hit_d       = hit_q;
    hit_idx_d   = hit_idx_q;
    hit_mask_d  = hit_mask_q;
    hit_count_d = hit_count_q;

    // Fold the slot evaluated this cycle; the first hit found is the lowest index.
    if (slot_hit) begin
      hit_d       = 1'b1;
      hit_mask_d  = hit_mask_q | (N_BULLETS'(1) << eval_idx_q);
      hit_count_d = hit_count_q + (IDX_W+1)'(1);
      if (!hit_q) hit_idx_d = eval_idx_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          player_d    = '{x: px, y: py, lx: lpx, ly: lpy};
          fo_d        = first_only;
          rd_idx_d    = '0;
          hit_d       = 1'b0;
          hit_idx_d   = '0;
          hit_mask_d  = '0;
          hit_count_d = '0;
          state_d     = S_SCAN;
        end
      end
      S_SCAN: begin
        eval_vld_d = 1'b1;
        eval_idx_d = rd_idx_q;
        if (slot_hit && fo_q) begin
          // Early stop: the read issued this cycle is dropped.
          eval_vld_d = 1'b0;
          state_d    = S_DONE;
        end else if (rd_idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          rd_idx_d = rd_idx_q + IDX_W'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;   // last slot is evaluated here
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      player_q    <= '0;
      fo_q        <= 1'b0;
      rd_idx_q    <= '0;
      eval_vld_q  <= 1'b0;
      eval_idx_q  <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      hit_mask_q  <= '0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      player_q    <= player_d;
      fo_q        <= fo_d;
      rd_idx_q    <= rd_idx_d;
      eval_vld_q  <= eval_vld_d;
      eval_idx_q  <= eval_idx_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
      hit_mask_q  <= hit_mask_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign rd_idx    = rd_idx_q;
  assign busy      = (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign hit       = hit_q;
  assign hit_idx   = hit_idx_q;
  assign hit_mask  = hit_mask_q;
  assign hit_count = hit_count_q;

endmodule
